// File: rtl/syscall_reader.sv
// rtl/syscall_reader.sv - read_int / read_char syscall service fed by a host ASCII byte stream
module syscall_reader #(
  parameter logic [31:0] V0_READ_INT  = 32'd5,
  parameter logic [31:0] V0_READ_CHAR = 32'd12,
  parameter int          MAX_DIGITS   = 10,
  parameter logic [7:0]  TERM_CHAR    = 8'h0A
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        syscall_control,
  input  logic [31:0] v0,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        stall,
  output logic        wb_valid,
  output logic [31:0] wb_data,
  output logic        err
);

  localparam int             CW      = $clog2(MAX_DIGITS + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_DIGITS);

  typedef enum logic [2:0] {IDLE, SKIP, DIGITS, CHAR_WAIT, DONE} state_t;

  state_t        state, state_d;
  logic [31:0]   acc, acc_d;
  logic          sign, sign_d;
  logic [CW-1:0] cnt, cnt_d;
  logic          err_flag, err_flag_d;
  logic [31:0]   wb_q;
  logic          err_q;

  logic          take;
  logic          is_digit;
  logic          is_term;
  logic          is_read_int;
  logic          is_read_char;
  logic [31:0]   digit_val;
  logic [31:0]   acc_x10;
  logic [31:0]   result;

  assign is_read_int  = syscall_control && (v0 == V0_READ_INT);
  assign is_read_char = syscall_control && (v0 == V0_READ_CHAR);
  assign is_digit     = (rx_data >= 8'h30) && (rx_data <= 8'h39);
  assign is_term      = (rx_data == TERM_CHAR) || (rx_data == 8'h0D);
  assign digit_val    = {28'd0, rx_data[3:0]};
  assign acc_x10      = (acc << 3) + (acc << 1);
  assign result       = sign ? (~acc + 32'd1) : acc;
  assign take         = rx_valid && rx_ready;

  // Handshake, stall and writeback outputs; wb_data/err show the fresh result in DONE, then hold it
  always_comb begin
    rx_ready = (state == SKIP) || (state == DIGITS) || (state == CHAR_WAIT);
    stall    = rx_ready || ((state == IDLE) && (is_read_int || is_read_char));
    wb_valid = (state == DONE);
    wb_data  = (state == DONE) ? result : wb_q;
    err      = (state == DONE) ? err_flag : err_q;
  end

  // Next-state and parse datapath
  always_comb begin
    state_d    = state;
    acc_d      = acc;
    sign_d     = sign;
    cnt_d      = cnt;
    err_flag_d = err_flag;
    case (state)
      IDLE: begin
        if (is_read_int || is_read_char) begin
          acc_d      = 32'd0;
          sign_d     = 1'b0;
          cnt_d      = '0;
          err_flag_d = 1'b0;
          state_d    = is_read_int ? SKIP : CHAR_WAIT;
        end
      end
      SKIP: begin
        if (take) begin
          if (rx_data == 8'h20) begin
            state_d = SKIP;
          end else if (rx_data == 8'h2D) begin
            sign_d  = 1'b1;
            state_d = DIGITS;
          end else if (rx_data == 8'h2B) begin
            state_d = DIGITS;
          end else if (is_digit) begin
            acc_d   = digit_val;
            cnt_d   = CW'(1);
            state_d = DIGITS;
          end else if (is_term) begin
            err_flag_d = 1'b1;
            state_d    = DONE;
          end else begin
            err_flag_d = 1'b1;
          end
        end
      end
      DIGITS: begin
        if (take) begin
          if (is_digit) begin
            if (cnt < MAX_CNT) begin
              acc_d = acc_x10 + digit_val;
              cnt_d = cnt + CW'(1);
            end else begin
              err_flag_d = 1'b1;
            end
          end else if (is_term) begin
            if (cnt == '0) err_flag_d = 1'b1;
            state_d = DONE;
          end else begin
            err_flag_d = 1'b1;
          end
        end
      end
      CHAR_WAIT: begin
        if (take) begin
          acc_d   = {24'd0, rx_data};
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and parse registers; result is latched on leaving DONE so it holds afterwards
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      acc      <= 32'd0;
      sign     <= 1'b0;
      cnt      <= '0;
      err_flag <= 1'b0;
      wb_q     <= 32'd0;
      err_q    <= 1'b0;
    end else begin
      state    <= state_d;
      acc      <= acc_d;
      sign     <= sign_d;
      cnt      <= cnt_d;
      err_flag <= err_flag_d;
      if (state == DONE) begin
        wb_q  <= result;
        err_q <= err_flag;
      end
    end
  end

endmodule

// File: tb/tb_syscall_reader.sv
// tb/tb_syscall_reader.sv - directed self-checking bench for syscall_reader
module tb_syscall_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        syscall_control;
  logic [31:0] v0;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        stall;
  logic        wb_valid;
  logic [31:0] wb_data;
  logic        err;

  int n_cmp = 0;
  int n_bad = 0;

  syscall_reader dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .syscall_control (syscall_control),
    .v0              (v0),
    .rx_valid        (rx_valid),
    .rx_data         (rx_data),
    .rx_ready        (rx_ready),
    .stall           (stall),
    .wb_valid        (wb_valid),
    .wb_data         (wb_data),
    .err             (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue a read_int syscall, stream the bytes back-to-back, then check the writeback
  task automatic read_int(input string tag, input string s, input logic [31:0] exp_data, input logic exp_err);
    @(negedge clk);
    syscall_control = 1'b1;
    v0 = 32'd5;
    #1 check({tag, "_stall_sc"}, {31'd0, stall}, 32'd1);
    @(negedge clk);
    syscall_control = 1'b0;
    v0 = 32'd0;
    for (int i = 0; i < s.len(); i++) begin
      rx_valid = 1'b1;
      rx_data  = s[i];
      #1;
      if (i == 0) begin
        check({tag, "_stall_rx"}, {31'd0, stall}, 32'd1);
        check({tag, "_ready_rx"}, {31'd0, rx_ready}, 32'd1);
      end
      @(negedge clk);
    end
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    #1;
    check({tag, "_wb_valid"}, {31'd0, wb_valid}, 32'd1);
    check({tag, "_wb_data"}, wb_data, exp_data);
    check({tag, "_err"}, {31'd0, err}, {31'd0, exp_err});
    check({tag, "_stall_done"}, {31'd0, stall}, 32'd0);
    @(negedge clk);
    #1;
    check({tag, "_wb_valid_off"}, {31'd0, wb_valid}, 32'd0);
    check({tag, "_wb_hold"}, wb_data, exp_data);
    check({tag, "_err_hold"}, {31'd0, err}, {31'd0, exp_err});
  endtask

  initial begin
    int stall_cycles;
    rst_n = 1'b0;
    syscall_control = 1'b0;
    v0 = 32'd0;
    rx_valid = 1'b0;
    rx_data = 8'h00;
    repeat (2) @(negedge clk);
    #1;
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_ready", {31'd0, rx_ready}, 32'd0);
    check("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    check("rst_wb_data", wb_data, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    rst_n = 1'b1;

    read_int("int123", "123\n", 32'h0000007B, 1'b0);
    read_int("neg45", "  -45\r", 32'hFFFFFFD3, 1'b0);
    read_int("junk", "12a3\n", 32'd123, 1'b1);
    read_int("empty", "\n", 32'd0, 1'b1);
    read_int("wrap", "4294967296\n", 32'd0, 1'b0);
    read_int("toolong", "12345678901\n", 32'd1234567890, 1'b1);
    read_int("signonly", "-\n", 32'd0, 1'b1);

    // Unserviced syscall code is ignored
    @(negedge clk);
    syscall_control = 1'b1;
    v0 = 32'd4;
    #1 check("other_stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    syscall_control = 1'b0;
    #1 check("other_ready", {31'd0, rx_ready}, 32'd0);

    // read_char with the byte arriving after five cycles without rx_valid
    stall_cycles = 0;
    @(negedge clk);
    syscall_control = 1'b1;
    v0 = 32'd12;
    for (int c = 0; c < 6; c++) begin
      if (c == 5) begin
        rx_valid = 1'b1;
        rx_data  = 8'h41;
      end
      #1;
      if (stall) stall_cycles++;
      @(negedge clk);
      syscall_control = 1'b0;
      v0 = 32'd0;
    end
    rx_valid = 1'b0;
    #1;
    check("char_stall_cycles", stall_cycles, 32'd6);
    check("char_wb_valid", {31'd0, wb_valid}, 32'd1);
    check("char_wb_data", wb_data, 32'h00000041);
    check("char_err", {31'd0, err}, 32'd0);
    check("char_stall_done", {31'd0, stall}, 32'd0);

    // Reset in the middle of a read_int discards the partial value
    @(negedge clk);
    syscall_control = 1'b1;
    v0 = 32'd5;
    @(negedge clk);
    syscall_control = 1'b0;
    rx_valid = 1'b1;
    rx_data = "9";
    @(negedge clk);
    rx_data = "8";
    @(negedge clk);
    rx_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("mid_rst_stall", {31'd0, stall}, 32'd0);
    check("mid_rst_ready", {31'd0, rx_ready}, 32'd0);
    check("mid_rst_wb_data", wb_data, 32'd0);
    check("mid_rst_err", {31'd0, err}, 32'd0);
    read_int("after_rst", "7\n", 32'd7, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
